fe_add_arb: RTL and testbench
=============================

FE_ADD_ARB -- requirements
Module: fe_add_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of requesters sharing one fe_add unit (2..8).
REQ-002 The block SHALL have parameter W, default 320, the field-element width (10 limbs x 32 bits).
REQ-003 The block SHALL have parameter ADD_LAT, default 1, the number of cycles from the fe_add unit sampling f/g to h being valid.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: grant enable; low blocks new grants.
REQ-007 The block SHALL have port req_valid, input, NREQ bits: per-requester operation request.
REQ-008 The block SHALL have port req_ready, output, NREQ bits: one-hot grant, combinational from req_valid, en and arbiter state.
REQ-009 The block SHALL have port req_f, input, NREQ*W bits: f operand, requester i in bits [i*W +: W].
REQ-010 The block SHALL have port req_g, input, NREQ*W bits: g operand, same packing as req_f.
REQ-011 The block SHALL have port add_f, output, W bits: registered f to the shared fe_add.
REQ-012 The block SHALL have port add_g, output, W bits: registered g to the shared fe_add.
REQ-013 The block SHALL have port add_h, input, W bits: h from the shared fe_add.
REQ-014 The block SHALL have port rsp_valid, output, NREQ bits: one-hot, one-cycle result strobe per requester.
REQ-015 The block SHALL have port rsp_h, output, W bits: registered result, shared by all requesters.
REQ-016 The block SHALL have port busy, output, 1 bit: high while any operation is in flight.

Function
REQ-017 A handshake on requester i in cycle N SHALL be req_valid[i] & req_ready[i]; at most one handshake per cycle.
REQ-018 req_ready SHALL be all-zero when en=0 or req_valid=0; otherwise exactly one bit is set, for the first valid requester found scanning from rr_ptr upward modulo NREQ.
REQ-019 req_ready SHALL NOT depend on req_f or req_g.
REQ-020 After a handshake on i, rr_ptr SHALL become (i+1) mod NREQ; with no handshake, rr_ptr SHALL hold.
REQ-021 On a handshake in cycle N, add_f/add_g SHALL carry the winner's operands unmodified from cycle N+1; with no handshake they SHALL hold their previous value.
REQ-022 The block SHALL carry a {valid, index} tag through a 1+ADD_LAT stage shift pipeline aligned with the add_h capture.
REQ-023 For a handshake on i in cycle N, rsp_valid SHALL be exactly bit i, for cycle N+2+ADD_LAT only, with rsp_h = add_h sampled at end of cycle N+1+ADD_LAT.
REQ-024 Issue throughput SHALL be one operation per cycle; back-to-back operations SHALL return in issue order with no gaps inserted.
REQ-025 Responses SHALL have no back-pressure; a requester must accept rsp_valid when it is strobed.
REQ-026 busy SHALL be high from the cycle after a handshake until the cycle its rsp_valid is asserted, inclusive.
REQ-027 Deasserting en SHALL stop new grants only; in-flight operations SHALL complete and respond normally.
REQ-028 A requester dropping req_valid without a handshake SHALL leave no state change.

Reset
REQ-029 While rst is high, all of the following SHALL be zero: req_ready, rsp_valid, rsp_h, add_f, add_g, busy, rr_ptr and all tag valids.
REQ-030 rst asserted mid-operation SHALL discard all in-flight tags; no rsp_valid SHALL be emitted for them after release.
REQ-031 The first grant after rst release SHALL be eligible in the first cycle rst is low.

Configuration
REQ-032 With FE_ADD_ARB_PRIO_EN defined, requester 0 SHALL win whenever req_valid[0]=1; the remaining requesters SHALL be arbitrated round-robin as in REQ-018/REQ-020, and rr_ptr SHALL be left unchanged by requester-0 grants.
REQ-033 Without FE_ADD_ARB_PRIO_EN, all requesters SHALL be pure round-robin with no priority logic synthesized.

Verification (NREQ=4, ADD_LAT=1, behavioral fe_add, handshake in cycle 0)
REQ-034 The bench SHALL cover: req_valid=0001, f=0, g=1 -> req_ready=0001 in cycle 0; add_f=0, add_g=1 in cycle 1; rsp_valid=0001, rsp_h=1 in cycle 3; busy high in cycles 1-3.
REQ-035 The bench SHALL cover: req_valid=1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid order is identical, each arriving 3 cycles after its grant.
REQ-036 The bench SHALL cover: req_valid=1111, en=0 in cycle 2 -> no grants from cycle 2; responses for cycles 0-1 still arrive in cycles 3-4; busy falls in cycle 5.
REQ-037 The bench SHALL cover: handshakes in cycles 0-1, then rst pulsed in cycle 2 -> rsp_valid never asserted; all outputs zero; next grant is to requester 0.
REQ-038 The bench SHALL cover, with FE_ADD_ARB_PRIO_EN defined and req_valid=1111 held -> every grant goes to requester 0; with req_valid=1110 -> grants 1,2,3,1.

Source files
------------

// File: rtl/fe_add_arb.sv
// rtl/fe_add_arb.sv - round-robin arbiter sharing one fe_add unit among NREQ requesters
// Optional build macro FE_ADD_ARB_PRIO_EN: requester 0 gets fixed priority over the round-robin ring.
module fe_add_arb #(
  parameter int NREQ    = 4,
  parameter int W       = 320,
  parameter int ADD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_f,
  input  logic [NREQ*W-1:0] req_g,
  output logic [W-1:0]      add_f,
  output logic [W-1:0]      add_g,
  input  logic [W-1:0]      add_h,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_h,
  output logic              busy
);

  localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 1 + ADD_LAT;
  localparam logic [IW:0]   NREQ_X   = (IW+1)'(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   ptr_nxt;
  logic [IW:0]     pos;
  logic            hs;
  logic            ptr_upd;
  logic [NREQ-1:0] scan_valid;
  logic [W-1:0]    sel_f;
  logic [W-1:0]    sel_g;
  logic [DEPTH-1:0] tag_v;
  logic [IW-1:0]   tag_i [DEPTH];
  logic [NREQ-1:0] rsp_nxt;

`ifdef FE_ADD_ARB_PRIO_EN
  // requester 0 is handled outside the ring and never moves the pointer
  assign scan_valid = {req_valid[NREQ-1:1], 1'b0};
  assign ptr_upd    = hs && !req_ready[0];
`else
  assign scan_valid = req_valid;
  assign ptr_upd    = hs;
`endif

  always_comb begin
    req_ready = '0;
    win       = '0;
    pos       = '0;
    if (!rst && en) begin
      for (int k = 0; k < NREQ; k++) begin
        pos = {1'b0, rr_ptr} + (IW+1)'(k);
        if (pos >= NREQ_X) pos = pos - NREQ_X;
        if (req_ready == '0 && scan_valid[pos[IW-1:0]]) begin
          req_ready[pos[IW-1:0]] = 1'b1;
          win = pos[IW-1:0];
        end
      end
`ifdef FE_ADD_ARB_PRIO_EN
      if (req_valid[0]) begin
        req_ready    = '0;
        req_ready[0] = 1'b1;
        win          = '0;
      end
`endif
    end
  end

  assign hs      = |req_ready;
  assign ptr_nxt = (win == LAST_IDX) ? '0 : win + IW'(1);

  always_comb begin
    sel_f = '0;
    sel_g = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_f = req_f[i*W +: W];
        sel_g = req_g[i*W +: W];
      end
    end
  end

  always_comb begin
    rsp_nxt = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_nxt[i] = tag_v[DEPTH-1] && (tag_i[DEPTH-1] == IW'(i));
    end
  end

  // tag pipeline last stage lines up with the cycle add_h holds this op's sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      add_f     <= '0;
      add_g     <= '0;
      tag_v     <= '0;
      for (int s = 0; s < DEPTH; s++) tag_i[s] <= '0;
      rsp_valid <= '0;
      rsp_h     <= '0;
    end else begin
      if (ptr_upd) rr_ptr <= ptr_nxt;
      if (hs) begin
        add_f <= sel_f;
        add_g <= sel_g;
      end
      tag_v    <= {tag_v[DEPTH-2:0], hs};
      tag_i[0] <= win;
      for (int s = 1; s < DEPTH; s++) tag_i[s] <= tag_i[s-1];
      rsp_valid <= rsp_nxt;
      if (tag_v[DEPTH-1]) rsp_h <= add_h;
    end
  end

  assign busy = (|tag_v) || (|rsp_valid);

endmodule

// File: tb/tb_fe_add_arb.sv
// tb/tb_fe_add_arb.sv - randomized and directed self-checking bench for fe_add_arb
module tb_fe_add_arb;
  localparam int NREQ    = 4;
  localparam int W       = 320;
  localparam int ADD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_f = '0;
  logic [NREQ*W-1:0] req_g = '0;
  logic [W-1:0]      add_f;
  logic [W-1:0]      add_g;
  logic [W-1:0]      add_h = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_h;
  logic              busy;

  fe_add_arb #(.NREQ(NREQ), .W(W), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_f(req_f), .req_g(req_g),
    .add_f(add_f), .add_g(add_g), .add_h(add_h),
    .rsp_valid(rsp_valid), .rsp_h(rsp_h), .busy(busy)
  );

  always #5 clk = ~clk;

  // behavioural single-stage fe_add
  always_ff @(posedge clk) add_h <= add_f + add_g;

  typedef struct {
    int           issue;
    int           due;
    int           idx;
    logic [W-1:0] h;
  } op_t;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  op_t pend[$];
  int mptr = 0;
  logic [W-1:0] mf = '0, mg = '0, mh = '0;

  logic            d_rst = 1'b1;
  logic            d_en = 1'b1;
  logic [NREQ-1:0] d_valid = '0;
  logic [W-1:0]    d_f [NREQ];
  logic [W-1:0]    d_g [NREQ];

  logic [NREQ-1:0] o_rdy, o_rv;
  logic [W-1:0]    o_rh, o_af, o_ag;
  logic            o_busy;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
`ifdef FE_ADD_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (ptr + k) % NREQ;
`ifdef FE_ADD_ARB_PRIO_EN
      if (i == 0) continue;
`endif
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int j = 0; j < W/32; j++) v[j*32 +: 32] = $urandom;
    if ($urandom_range(0, 7) == 0) v = '1;
    return v;
  endfunction

  task automatic cycle();
    int g;
    logic [NREQ-1:0] erdy, erv;
    logic ebusy;
    op_t op;
    @(posedge clk);
    #1;
    rst = d_rst;
    en = d_en;
    req_valid = d_valid;
    for (int i = 0; i < NREQ; i++) begin
      req_f[i*W +: W] = d_f[i];
      req_g[i*W +: W] = d_g[i];
    end
    if (d_rst) begin
      pend.delete();
      mptr = 0;
      mf = '0;
      mg = '0;
      mh = '0;
    end
    #1;
    o_rdy = req_ready; o_rv = rsp_valid; o_rh = rsp_h;
    o_af = add_f; o_ag = add_g; o_busy = busy;
    g = (d_rst || !d_en) ? -1 : pick(d_valid, mptr);
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    erv = '0;
    ebusy = 1'b0;
    foreach (pend[j]) begin
      if (pend[j].due == cyc) begin
        erv[pend[j].idx] = 1'b1;
        mh = pend[j].h;
      end
      if (pend[j].issue < cyc && pend[j].due >= cyc) ebusy = 1'b1;
    end
    check("m_ready", W'(o_rdy), W'(erdy));
    check("m_rsp_valid", W'(o_rv), W'(erv));
    check("m_rsp_h", o_rh, mh);
    check("m_add_f", o_af, mf);
    check("m_add_g", o_ag, mg);
    check("m_busy", W'(o_busy), W'(ebusy));
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    if (g >= 0) begin
      op.issue = cyc;
      op.due = cyc + 2 + ADD_LAT;
      op.idx = g;
      op.h = d_f[g] + d_g[g];
      pend.push_back(op);
      mf = d_f[g];
      mg = d_g[g];
`ifdef FE_ADD_ARB_PRIO_EN
      if (g != 0) mptr = (g + 1) % NREQ;
`else
      mptr = (g + 1) % NREQ;
`endif
    end
    cyc++;
  endtask

  task automatic do_reset();
    d_rst = 1'b1;
    d_en = 1'b1;
    d_valid = '0;
    cycle();
    d_rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] eg;
    int gl [4];
    for (int i = 0; i < NREQ; i++) begin
      d_f[i] = rand_w();
      d_g[i] = rand_w();
    end

    // reset with active requests: nothing granted, all zero
    d_rst = 1'b1; d_en = 1'b1; d_valid = '1;
    cycle();
    check("rst_ready", W'(o_rdy), '0);
    check("rst_busy", W'(o_busy), '0);
    d_rst = 1'b0;

    // single op on requester 0
    do_reset();
    d_f[0] = '0; d_g[0] = W'(1); d_valid = 4'b0001;
    cycle();
    check("t1_ready_c0", W'(o_rdy), W'(4'b0001));
    d_valid = '0;
    cycle();
    check("t1_add_f_c1", o_af, '0);
    check("t1_add_g_c1", o_ag, W'(1));
    check("t1_busy_c1", W'(o_busy), W'(1));
    cycle();
    check("t1_busy_c2", W'(o_busy), W'(1));
    cycle();
    check("t1_rsp_valid_c3", W'(o_rv), W'(4'b0001));
    check("t1_rsp_h_c3", o_rh, W'(1));
    check("t1_busy_c3", W'(o_busy), W'(1));
    cycle();
    check("t1_busy_c4", W'(o_busy), '0);

    // all requesting for 8 cycles
    do_reset();
    for (int k = 0; k < 12; k++) begin
      d_valid = (k < 8) ? 4'b1111 : 4'b0000;
      cycle();
`ifdef FE_ADD_ARB_PRIO_EN
      eg = 4'b0001;
`else
      eg = NREQ'(1) << (k % NREQ);
`endif
      if (k < 8) check("rr_grant", W'(o_rdy), W'(eg));
`ifndef FE_ADD_ARB_PRIO_EN
      eg = NREQ'(1) << ((k + NREQ - 3) % NREQ);
`endif
      if (k >= 3 && k < 11) check("rr_rsp_order", W'(o_rv), W'(eg));
    end

`ifdef FE_ADD_ARB_PRIO_EN
    do_reset();
    gl = '{1, 2, 3, 1};
    for (int k = 0; k < 4; k++) begin
      d_valid = 4'b1110;
      cycle();
      eg = NREQ'(1) << gl[k];
      check("prio_ring_grant", W'(o_rdy), W'(eg));
    end
`else
    gl = '{0, 0, 0, 0};
`endif

    // en dropped in cycle 2
    do_reset();
    for (int k = 0; k < 6; k++) begin
      d_en = (k < 2);
      d_valid = 4'b1111;
      cycle();
      if (k >= 2) check("en_no_grant", W'(o_rdy), '0);
      if (k == 3) check("en_rsp_c3", W'(o_rv), W'(4'b0001));
`ifdef FE_ADD_ARB_PRIO_EN
      if (k == 4) check("en_rsp_c4", W'(o_rv), W'(4'b0001));
`else
      if (k == 4) check("en_rsp_c4", W'(o_rv), W'(4'b0010));
`endif
      if (k == 4) check("en_busy_c4", W'(o_busy), W'(1));
      if (k == 5) check("en_busy_c5", W'(o_busy), '0);
    end
    d_en = 1'b1;

    // reset mid-flight discards tags
    do_reset();
    d_valid = 4'b1111;
    cycle();
    cycle();
    d_rst = 1'b1;
    cycle();
    check("mid_rst_ready", W'(o_rdy), '0);
    check("mid_rst_rsp_valid", W'(o_rv), '0);
    check("mid_rst_rsp_h", o_rh, '0);
    check("mid_rst_add_f", o_af, '0);
    check("mid_rst_add_g", o_ag, '0);
    check("mid_rst_busy", W'(o_busy), '0);
    d_rst = 1'b0;
    d_valid = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("post_rst_no_rsp", W'(o_rv), '0);
    end
    d_valid = 4'b1111;
    cycle();
    check("post_rst_grant0", W'(o_rdy), W'(4'b0001));

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      d_rst = ($urandom_range(0, 59) == 0);
      d_en = ($urandom_range(0, 7) != 0);
      d_valid = ($urandom_range(0, 5) == 0) ? '0 : NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        d_f[i] = rand_w();
        d_g[i] = rand_w();
      end
      cycle();
    end

    d_rst = 1'b0;
    d_en = 1'b1;
    d_valid = '0;
    for (int k = 0; k < 6; k++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
